// File: rtl/ahb_slave_mem_pkg.sv
// Shared AHB slave definitions: transfer types, slave FSM states and
// HSIZE/HRESP encodings.
package ahb_slave_mem_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } trans_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_DATA,
      S_ERR1,
      S_ERR2
   } slv_state_t;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   // NONSEQ and SEQ carry a data phase; IDLE and BUSY do not.
   function automatic logic trans_active(input trans_t t);
      return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
   endfunction

endpackage

// File: rtl/ahb_byte_lane_dec.sv
// Maps a transfer size and the low address bits onto little-endian byte
// lane enables of a 32-bit bus, flagging unsupported sizes and misalignment.
module ahb_byte_lane_dec
   import ahb_slave_mem_pkg::*;
(
   input  logic [2:0] size,
   input  logic [1:0] addr,
   output logic [3:0] be,
   output logic       err
);

   // Lane enables and size/alignment check.
   always_comb begin
      be  = '0;
      err = 1'b0;
      case (size)
         HSIZE_BYTE: be = 4'b0001 << addr;
         HSIZE_HALF: begin
            if (addr[0]) err = 1'b1;
            else         be  = addr[1] ? 4'b1100 : 4'b0011;
         end
         HSIZE_WORD: begin
            if (addr != 2'b00) err = 1'b1;
            else               be  = '1;
         end
         default: err = 1'b1;
      endcase
   end

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory slave: word array with byte-lane writes, configurable
// wait states on every good data phase and a two-cycle ERROR response for
// out-of-range, misaligned or oversized transfers.
module ahb_slave_mem
   import ahb_slave_mem_pkg::*;
#(
   parameter int unsigned          WIDTH       = 32,
   parameter int unsigned          DEPTH       = 256,
   parameter logic [WIDTH-1:0]     BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned          WAIT_STATES = 0
) (
   input  logic             HCLK,
   input  logic             HRESET,
   input  logic             HSEL,
   input  logic [WIDTH-1:0] HADDR,
   input  trans_t           HTRANS,
   input  logic             HWRITE,
   input  logic [2:0]       HSIZE,
   input  logic [2:0]       HBURST,
   input  logic [3:0]       HPROT,
   input  logic             HMASTLOCK,
   input  logic [WIDTH-1:0] HWDATA,
   input  logic             HREADY,
   output logic             HREADYOUT,
   output logic             HRESP,
   output logic [WIDTH-1:0] HRDATA
);

   localparam int unsigned      AW   = $clog2(DEPTH);
   localparam logic [WIDTH-1:0] SPAN = WIDTH'(DEPTH * 4);
   localparam logic [2:0]       WS   = 3'(WAIT_STATES);

   slv_state_t       state, state_nx;
   logic [2:0]       wcnt, wcnt_nx;

   logic [WIDTH-1:0] addr_q;
   logic             write_q;
   logic [2:0]       size_q;
   logic             err_q;

   logic             borrow;
   logic [WIDTH-1:0] offset;
   logic             in_range;
   logic [3:0]       be_addr;
   logic             lane_err_addr;
   logic [3:0]       be_commit;
   logic             lane_err_commit;

   logic             can_accept;
   logic             accept;
   logic             err_d;
   logic             commit;
   logic [AW-1:0]    idx;

   logic [WIDTH-1:0] mem [DEPTH];

   logic             unused;
   assign unused = ^{HBURST, HPROT, HMASTLOCK, lane_err_commit};

   // Address-phase decode on the live bus.
   ahb_byte_lane_dec u_dec_addr (
      .size (HSIZE),
      .addr (HADDR[1:0]),
      .be   (be_addr),
      .err  (lane_err_addr)
   );

   // Lane enables for the registered transfer being committed.
   ahb_byte_lane_dec u_dec_commit (
      .size (size_q),
      .addr (addr_q[1:0]),
      .be   (be_commit),
      .err  (lane_err_commit)
   );

   // Borrow out of the subtraction means HADDR is below the window.
   assign {borrow, offset} = {1'b0, HADDR} - {1'b0, BASE_ADDR};
   assign in_range   = !borrow && (offset < SPAN);
   assign err_d      = !in_range || lane_err_addr || (be_addr == 4'b0000);

   // Only states whose data phase is ending (or idle) can take a new address.
   assign can_accept = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);
   assign accept     = HSEL && HREADY && trans_active(HTRANS) && can_accept;

   assign idx    = AW'((addr_q - BASE_ADDR) >> 2);
   assign commit = (state == S_DATA) && write_q && !err_q;

   // State, wait counter and address-phase capture.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state   <= S_IDLE;
         wcnt    <= '0;
         addr_q  <= '0;
         write_q <= 1'b0;
         size_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state <= state_nx;
         wcnt  <= wcnt_nx;
         if (accept) begin
            addr_q  <= HADDR;
            write_q <= HWRITE;
            size_q  <= HSIZE;
            err_q   <= err_d;
         end
      end
   end

   // Next state and response outputs; the error decision uses the value
   // being loaded into err_q at this edge.
   always_comb begin
      state_nx  = state;
      wcnt_nx   = wcnt;
      HREADYOUT = 1'b1;
      HRESP     = HRESP_OKAY;
      case (state)
         S_WAIT: begin
            HREADYOUT = 1'b0;
            if (wcnt <= 3'd1) begin
               state_nx = S_DATA;
               wcnt_nx  = '0;
            end else begin
               wcnt_nx = wcnt - 3'd1;
            end
         end
         S_ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = HRESP_ERROR;
            state_nx  = S_ERR2;
         end
         S_ERR2: HRESP = HRESP_ERROR;
         default: ;
      endcase
      if (accept) begin
         if (err_d) begin
            state_nx = S_ERR1;
         end else if (WS != 3'd0) begin
            state_nx = S_WAIT;
            wcnt_nx  = WS;
         end else begin
            state_nx = S_DATA;
         end
      end else if (can_accept) begin
         state_nx = S_IDLE;
      end
   end

   // Byte-lane write at the edge ending the data phase; reset drops it.
   always_ff @(posedge HCLK) begin
      if (!HRESET && commit) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (be_commit[b]) mem[idx][8*b +: 8] <= HWDATA[8*b +: 8];
         end
      end
   end

   assign HRDATA = ((state == S_DATA) && !write_q && !err_q) ? mem[idx] : '0;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: two instances (0 and 3 wait states) share one
// master; a byte-addressed reference memory predicts every cycle's response.
module tb_ahb_slave_mem;
   import ahb_slave_mem_pkg::*;

   localparam int DEPTH = 256;

   typedef struct {
      trans_t      tr;
      logic        wr;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] wdata;
   } op_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        hsel;
   logic [31:0] haddr;
   logic [31:0] hwdata;
   trans_t      htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic        sel;

   logic        rdy0, rdy3, resp0, resp3;
   logic [31:0] rd0, rd3;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] mdl [2][DEPTH];
   op_t         ops [$];
   logic [31:0] last_rd;

   always #5 clk = ~clk;

   ahb_slave_mem #(.WIDTH(32), .DEPTH(DEPTH), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut0 (
      .HCLK(clk), .HRESET(rst), .HSEL(hsel && (sel == 1'b0)), .HADDR(haddr),
      .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000),
      .HPROT(4'b0011), .HMASTLOCK(1'b0), .HWDATA(hwdata), .HREADY(rdy0),
      .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rd0)
   );

   ahb_slave_mem #(.WIDTH(32), .DEPTH(DEPTH), .BASE_ADDR(32'h0), .WAIT_STATES(3)) dut3 (
      .HCLK(clk), .HRESET(rst), .HSEL(hsel && (sel == 1'b1)), .HADDR(haddr),
      .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b001),
      .HPROT(4'b0011), .HMASTLOCK(1'b0), .HWDATA(hwdata), .HREADY(rdy3),
      .HREADYOUT(rdy3), .HRESP(resp3), .HRDATA(rd3)
   );

   function automatic op_t mk(trans_t tr, logic wr, logic [31:0] a, logic [2:0] sz, logic [31:0] d);
      op_t o;
      o.tr = tr; o.wr = wr; o.addr = a; o.size = sz; o.wdata = d;
      return o;
   endfunction

   // A transfer is rejected if it leaves the array, is wider than a word,
   // or its address is not a multiple of its byte count.
   function automatic bit mdl_err(logic [31:0] a, logic [2:0] sz);
      if (a >= 32'(4 * DEPTH)) return 1'b1;
      if (sz > 3'd2) return 1'b1;
      return (a % (32'd1 << sz)) != 0;
   endfunction

   // Store (1 << size) bytes starting at byte address a, little-endian.
   task automatic mdl_write(int s, logic [31:0] a, logic [2:0] sz, logic [31:0] d);
      int nb = 1 << sz;
      int w  = int'(a / 4);
      int l0 = int'(a % 4);
      for (int k = 0; k < nb; k++) mdl[s][w][8*(l0+k) +: 8] = d[8*(l0+k) +: 8];
   endtask

   // Drive the queued ops as a pipelined master and check every cycle.
   task automatic run_seq();
      int          n     = ops.size();
      int          idx   = 0;
      int          k     = 0;
      int          guard = 0;
      int          ws    = sel ? 3 : 0;
      int          s     = sel ? 1 : 0;
      bit          pv    = 0;
      bit          perr;
      bit          done;
      op_t         p;
      logic        r, e, exp_r, exp_e;
      logic [31:0] d, exp_d;
      while ((idx < n || pv) && guard < 20000) begin
         guard++;
         hsel = 1'b1;
         if (idx < n) begin
            htrans = ops[idx].tr; hwrite = ops[idx].wr;
            haddr  = ops[idx].addr; hsize = ops[idx].size;
         end else begin
            htrans = HTRANS_IDLE; hwrite = 1'b0; haddr = $urandom; hsize = 3'd2;
         end
         hwdata = pv ? p.wdata : $urandom;
         @(negedge clk);
         r = sel ? rdy3 : rdy0;
         e = sel ? resp3 : resp0;
         d = sel ? rd3 : rd0;
         exp_r = 1'b1; exp_e = 1'b0; exp_d = '0; done = 0;
         if (pv) begin
            perr = mdl_err(p.addr, p.size);
            if (perr) begin
               exp_r = (k == 1); exp_e = 1'b1; done = (k == 1);
            end else begin
               exp_r = (k == ws); done = (k == ws);
               if (done && !p.wr) exp_d = mdl[s][p.addr / 4];
            end
         end
         total += 3;
         if (r !== exp_r) begin
            bad++;
            $display("FAIL hreadyout: got %b want %b (dut=%0d addr=%h k=%0d t=%0t)", r, exp_r, s, p.addr, k, $time);
         end
         if (e !== exp_e) begin
            bad++;
            $display("FAIL hresp: got %b want %b (dut=%0d addr=%h k=%0d t=%0t)", e, exp_e, s, p.addr, k, $time);
         end
         if (d !== exp_d) begin
            bad++;
            $display("FAIL hrdata: got %h want %h (dut=%0d addr=%h k=%0d t=%0t)", d, exp_d, s, p.addr, k, $time);
         end
         if (done && pv && !p.wr) last_rd = d;
         @(posedge clk);
         if (pv) begin
            if (done) begin
               if (p.wr && !perr) mdl_write(s, p.addr, p.size, p.wdata);
               pv = 0;
            end else begin
               k++;
            end
         end
         if (r && idx < n) begin
            if (trans_active(ops[idx].tr)) begin
               p = ops[idx]; pv = 1; k = 0;
            end
            idx++;
         end
         #1;
      end
      if (guard >= 20000) begin
         bad++;
         $display("FAIL seq_timeout: got %0d cycles want completion", guard);
      end
      ops.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1; hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0;
      haddr = '0; hsize = 3'd2; hwdata = '0; sel = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      total += 6;
      if (rdy0 !== 1'b1) begin bad++; $display("FAIL reset_rdy0: got %b want 1", rdy0); end
      if (resp0 !== 1'b0) begin bad++; $display("FAIL reset_resp0: got %b want 0", resp0); end
      if (rd0 !== 32'h0) begin bad++; $display("FAIL reset_rd0: got %h want 0", rd0); end
      if (rdy3 !== 1'b1) begin bad++; $display("FAIL reset_rdy3: got %b want 1", rdy3); end
      if (resp3 !== 1'b0) begin bad++; $display("FAIL reset_resp3: got %b want 0", resp3); end
      if (rd3 !== 32'h0) begin bad++; $display("FAIL reset_rd3: got %h want 0", rd3); end
      @(posedge clk); #1;
   endtask

   task automatic preload();
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         for (int w = 0; w < DEPTH; w++)
            ops.push_back(mk(w == 0 ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b1, 32'(w * 4), 3'd2, $urandom));
         run_seq();
      end
   endtask

   task automatic test_basic();
      sel = 1'b0;
      ops.push_back(mk(HTRANS_NONSEQ, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF));
      ops.push_back(mk(HTRANS_NONSEQ, 1'b0, 32'h10, 3'd2, 32'h0));
      run_seq();
      total++;
      if (last_rd !== 32'hDEADBEEF) begin
         bad++; $display("FAIL basic_read: got %h want deadbeef", last_rd);
      end
   endtask

   task automatic test_byte_write();
      sel = 1'b0;
      ops.push_back(mk(HTRANS_NONSEQ, 1'b1, 32'h10, 3'd2, 32'h11223344));
      ops.push_back(mk(HTRANS_NONSEQ, 1'b1, 32'h13, 3'd0, 32'hAA000000));
      ops.push_back(mk(HTRANS_NONSEQ, 1'b0, 32'h10, 3'd2, 32'h0));
      run_seq();
      total++;
      if (last_rd !== 32'hAA223344) begin
         bad++; $display("FAIL byte_write: got %h want aa223344", last_rd);
      end
   endtask

   task automatic test_wait_states();
      sel = 1'b1;
      ops.push_back(mk(HTRANS_NONSEQ, 1'b0, 32'h20, 3'd2, 32'h0));
      ops.push_back(mk(HTRANS_NONSEQ, 1'b0, 32'h24, 3'd2, 32'h0));
      ops.push_back(mk(HTRANS_NONSEQ, 1'b1, 32'h28, 3'd1, 32'h5A5A_C3C3));
      ops.push_back(mk(HTRANS_NONSEQ, 1'b0, 32'h28, 3'd2, 32'h0));
      run_seq();
   endtask

   task automatic test_errors();
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         ops.push_back(mk(HTRANS_NONSEQ, 1'b0, 32'h400, 3'd2, 32'h0));
         ops.push_back(mk(HTRANS_NONSEQ, 1'b1, 32'h02, 3'd2, 32'hFFFF_FFFF));
         ops.push_back(mk(HTRANS_NONSEQ, 1'b1, 32'h05, 3'd1, 32'hFFFF_FFFF));
         ops.push_back(mk(HTRANS_NONSEQ, 1'b1, 32'h08, 3'd3, 32'hFFFF_FFFF));
         ops.push_back(mk(HTRANS_NONSEQ, 1'b1, 32'h404, 3'd2, 32'hFFFF_FFFF));
         ops.push_back(mk(HTRANS_NONSEQ, 1'b0, 32'h00, 3'd2, 32'h0));
         ops.push_back(mk(HTRANS_NONSEQ, 1'b0, 32'h04, 3'd2, 32'h0));
         ops.push_back(mk(HTRANS_NONSEQ, 1'b0, 32'h08, 3'd2, 32'h0));
         run_seq();
      end
   endtask

   task automatic test_idle_busy();
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         ops.push_back(mk(HTRANS_NONSEQ, 1'b1, 32'h100, 3'd2, $urandom));
         ops.push_back(mk(HTRANS_IDLE,   1'b1, 32'h200, 3'd2, $urandom));
         ops.push_back(mk(HTRANS_SEQ,    1'b1, 32'h104, 3'd2, $urandom));
         ops.push_back(mk(HTRANS_BUSY,   1'b1, 32'h204, 3'd2, $urandom));
         ops.push_back(mk(HTRANS_BUSY,   1'b1, 32'h208, 3'd0, $urandom));
         ops.push_back(mk(HTRANS_SEQ,    1'b1, 32'h108, 3'd2, $urandom));
         ops.push_back(mk(HTRANS_IDLE,   1'b0, 32'h20C, 3'd2, $urandom));
         for (int a = 'h200; a <= 'h208; a += 4)
            ops.push_back(mk(HTRANS_NONSEQ, 1'b0, 32'(a), 3'd2, 32'h0));
         for (int a = 'h100; a <= 'h108; a += 4)
            ops.push_back(mk(HTRANS_SEQ, 1'b0, 32'(a), 3'd2, 32'h0));
         run_seq();
      end
   endtask

   task automatic test_random();
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         for (int i = 0; i < 200; i++) begin
            logic [2:0]  sz;
            logic [31:0] a;
            sz = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
            a  = ($urandom_range(0, 9) < 9) ? 32'($urandom_range(0, 4 * DEPTH - 1))
                                            : 32'($urandom_range(4 * DEPTH, 8 * DEPTH));
            if ($urandom_range(0, 9) < 8 && sz <= 3'd2) a = a & ~((32'd1 << sz) - 32'd1);
            ops.push_back(mk(trans_t'($urandom_range(0, 3)), 1'($urandom), a, sz, $urandom));
         end
         run_seq();
      end
   endtask

   task automatic test_reset_mid();
      sel = 1'b1;
      hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b1; haddr = 32'h30; hsize = 3'd2;
      @(posedge clk); #1;
      htrans = HTRANS_IDLE; hwrite = 1'b0; hwdata = ~mdl[1][12];
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      total++;
      if (rdy3 !== 1'b0) begin bad++; $display("FAIL mid_wait_rdy: got %b want 0", rdy3); end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      total += 3;
      if (rdy3 !== 1'b1) begin bad++; $display("FAIL mid_reset_rdy: got %b want 1", rdy3); end
      if (resp3 !== 1'b0) begin bad++; $display("FAIL mid_reset_resp: got %b want 0", resp3); end
      if (rd3 !== 32'h0) begin bad++; $display("FAIL mid_reset_rdata: got %h want 0", rd3); end
      @(posedge clk); #1;
      ops.push_back(mk(HTRANS_NONSEQ, 1'b0, 32'h30, 3'd2, 32'h0));
      run_seq();
   endtask

   task automatic test_sweep();
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         for (int w = 0; w < DEPTH; w++)
            ops.push_back(mk(HTRANS_SEQ, 1'b0, 32'(w * 4), 3'd2, 32'h0));
         run_seq();
      end
   endtask

   initial begin
      test_reset();
      preload();
      test_basic();
      test_byte_write();
      test_wait_states();
      test_errors();
      test_idle_busy();
      test_random();
      test_reset_mid();
      test_sweep();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "simulation time limit exceeded");
   end

endmodule
